game_flow_ctrl: RTL and testbench

- Top-level game sequencer for the VGA puzzle game.
- Owns the screen state (TITLE/STAFF/STAGEk/SUCCESSk/FAIL) and the per-stage progress registers: lives, keys found, current task, stage unlock mask.
- Drives the state, heart, key_find, todo and play_valid inputs of the UI overlay renderer.
- Consumes one-pulse button events and gameplay event pulses from the player/collision logic.

---
 rtl/game_flow_ctrl_if.sv | 30 +++
 rtl/game_flow_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game sequencer, its button/gameplay pulse
// sources and the UI overlay renderer.
interface game_flow_ctrl_if;
    logic       btn_go;
    logic [1:0] menu_sel;
    logic       btn_next;
    logic       btn_back;
    logic       btn_retry;
    logic       key_pick;
    logic       light_found;
    logic       door_reached;
    logic       hit;
    logic [3:0] state;
    logic [1:0] heart;
    logic [1:0] key_find;
    logic [1:0] todo;
    logic [3:0] play_valid;

    modport master (
        output btn_go, menu_sel, btn_next, btn_back, btn_retry,
        output key_pick, light_found, door_reached, hit,
        input  state, heart, key_find, todo, play_valid
    );

    modport slave (
        input  btn_go, menu_sel, btn_next, btn_back, btn_retry,
        input  key_pick, light_found, door_reached, hit,
        output state, heart, key_find, todo, play_valid
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: owns the screen state, lives, keys, current task and the
// sticky stage-unlock mask; every output is a flop with one cycle of latency.
module game_flow_ctrl #(
    parameter int KEYS_NEEDED     = 3,
    parameter int HIT_GUARD       = 50_000_000,
    parameter int SUCCESS_TIMEOUT = 500_000_000,
    parameter int CNT_W           = 29
) (
    input  logic            clk,
    input  logic            rst,
    game_flow_ctrl_if.slave gif
);

    typedef enum logic [3:0] {
        S_TITLE    = 4'd0,
        S_STAFF    = 4'd1,
        S_STAGE1   = 4'd2,
        S_SUCCESS1 = 4'd3,
        S_STAGE2   = 4'd4,
        S_SUCCESS2 = 4'd5,
        S_STAGE3   = 4'd6,
        S_SUCCESS3 = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        TODO_NONE       = 2'd0,
        TODO_FIND_KEY   = 2'd1,
        TODO_FIND_LIGHT = 2'd2,
        TODO_FIND_DOOR  = 2'd3
    } todo_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(HIT_GUARD);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(SUCCESS_TIMEOUT);
    localparam logic [1:0]       KEYS_TGT     = 2'(KEYS_NEEDED);
    localparam logic [3:0]       PV_RESET     = 4'b0010;

    function automatic state_t success_of(input state_t stage);
        case (stage)
            S_STAGE1: success_of = S_SUCCESS1;
            S_STAGE2: success_of = S_SUCCESS2;
            S_STAGE3: success_of = S_SUCCESS3;
            default:  success_of = S_TITLE;
        endcase
    endfunction

    function automatic state_t next_stage_of(input state_t success);
        case (success)
            S_SUCCESS1: next_stage_of = S_STAGE2;
            S_SUCCESS2: next_stage_of = S_STAGE3;
            default:    next_stage_of = S_STAGE1;
        endcase
    endfunction

    // Clearing a stage unlocks the next one; clearing stage 3 sets the "all cleared" bit0.
    function automatic logic [3:0] unlock_mask(input state_t success);
        case (success)
            S_SUCCESS1: unlock_mask = 4'b0100;
            S_SUCCESS2: unlock_mask = 4'b1000;
            S_SUCCESS3: unlock_mask = 4'b0001;
            default:    unlock_mask = 4'b0000;
        endcase
    endfunction

    state_t           state_q, state_d;
    state_t           last_stage_q, last_stage_d;
    todo_t            todo_q, todo_d;
    logic [1:0]       heart_q, heart_d;
    logic [1:0]       key_find_q, key_find_d;
    logic [3:0]       play_valid_q, play_valid_d;
    logic [CNT_W-1:0] guard_q, guard_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;

    logic             enter_stage_s;
    logic             enter_success_s;
    logic             hit_ok_s;
    logic             door_ok_s;
    logic [1:0]       key_next_s;
    state_t           stage_sel_s;
    state_t           success_sel_s;

    // Next-state and progress-register update for the whole game flow.
    always_comb begin
        state_d         = state_q;
        last_stage_d    = last_stage_q;
        todo_d          = todo_q;
        heart_d         = heart_q;
        key_find_d      = key_find_q;
        play_valid_d    = play_valid_q;
        guard_d         = (guard_q != CNT_ZERO) ? guard_q - CNT_ONE : CNT_ZERO;
        timeout_d       = (timeout_q != CNT_ZERO) ? timeout_q - CNT_ONE : CNT_ZERO;
        enter_stage_s   = 1'b0;
        stage_sel_s     = S_STAGE1;
        enter_success_s = 1'b0;
        success_sel_s   = S_SUCCESS1;
        door_ok_s       = 1'b0;
        hit_ok_s        = gif.hit && (guard_q == CNT_ZERO);
        key_next_s      = (key_find_q == 2'd3) ? 2'd3 : key_find_q + 2'd1;

        case (state_q)
            S_TITLE: begin
                if (gif.btn_go) begin
                    case (gif.menu_sel)
                        2'd0: state_d = S_STAFF;
                        2'd1: begin
                            enter_stage_s = 1'b1;
                            stage_sel_s   = S_STAGE1;
                        end
                        2'd2: begin
                            enter_stage_s = play_valid_q[2];
                            stage_sel_s   = S_STAGE2;
                        end
                        2'd3: begin
                            enter_stage_s = play_valid_q[3];
                            stage_sel_s   = S_STAGE3;
                        end
                        default: state_d = S_TITLE;
                    endcase
                end else begin
                    state_d = S_TITLE;
                end
            end

            S_STAFF: begin
                if (gif.btn_back) begin
                    state_d = S_TITLE;
                end else begin
                    state_d = S_STAFF;
                end
            end

            S_STAGE1, S_STAGE2, S_STAGE3: begin
                // A fatal hit preempts everything else arriving in the same cycle.
                if (hit_ok_s && (heart_q <= 2'd1)) begin
                    state_d = S_FAIL;
                    heart_d = 2'd0;
                    todo_d  = TODO_NONE;
                end else begin
                    if (hit_ok_s) begin
                        heart_d = heart_q - 2'd1;
                        guard_d = GUARD_LOAD;
                    end else begin
                        heart_d = heart_q;
                    end

                    if (gif.key_pick && (todo_q == TODO_FIND_KEY)) begin
                        key_find_d = key_next_s;
                        if (key_next_s == KEYS_TGT) begin
                            todo_d = TODO_FIND_LIGHT;
                        end else begin
                            todo_d = TODO_FIND_KEY;
                        end
                    end else if (gif.light_found && (todo_q == TODO_FIND_LIGHT)) begin
                        todo_d = TODO_FIND_DOOR;
                    end else if (gif.door_reached && (todo_q == TODO_FIND_DOOR)) begin
                        door_ok_s       = 1'b1;
                        enter_success_s = 1'b1;
                        success_sel_s   = success_of(state_q);
                    end else begin
                        todo_d = todo_q;
                    end

                    if (gif.btn_back && !door_ok_s) begin
                        state_d = S_TITLE;
                    end else begin
                        state_d = state_q;
                    end
                end
            end

            S_SUCCESS1, S_SUCCESS2, S_SUCCESS3: begin
                if (gif.btn_next) begin
                    if (state_q == S_SUCCESS3) begin
                        state_d = S_STAFF;
                    end else begin
                        enter_stage_s = 1'b1;
                        stage_sel_s   = next_stage_of(state_q);
                    end
                end else if (gif.btn_back || (timeout_q <= CNT_ONE)) begin
                    // Leaving when the counter is at 1 lands on TITLE as it reaches 0.
                    state_d = S_TITLE;
                end else begin
                    state_d = state_q;
                end
            end

            S_FAIL: begin
                if (gif.btn_retry) begin
                    enter_stage_s = 1'b1;
                    stage_sel_s   = last_stage_q;
                end else if (gif.btn_back) begin
                    state_d = S_TITLE;
                end else begin
                    state_d = S_FAIL;
                end
            end

            default: begin
                state_d = S_TITLE;
                todo_d  = TODO_NONE;
            end
        endcase

        if (enter_stage_s) begin
            state_d      = stage_sel_s;
            last_stage_d = stage_sel_s;
            heart_d      = 2'd3;
            key_find_d   = 2'd0;
            todo_d       = TODO_FIND_KEY;
            guard_d      = CNT_ZERO;
        end else begin
            last_stage_d = last_stage_q;
        end

        if (enter_success_s) begin
            state_d      = success_sel_s;
            todo_d       = TODO_NONE;
            timeout_d    = TIMEOUT_LOAD;
            play_valid_d = play_valid_q | unlock_mask(success_sel_s);
        end else begin
            play_valid_d = play_valid_q;
        end
    end

    // State and progress registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_TITLE;
            last_stage_q <= S_STAGE1;
            todo_q       <= TODO_NONE;
            heart_q      <= 2'd0;
            key_find_q   <= 2'd0;
            play_valid_q <= PV_RESET;
            guard_q      <= CNT_ZERO;
            timeout_q    <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            last_stage_q <= last_stage_d;
            todo_q       <= todo_d;
            heart_q      <= heart_d;
            key_find_q   <= key_find_d;
            play_valid_q <= play_valid_d;
            guard_q      <= guard_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gif.state      = state_q;
    assign gif.heart      = heart_q;
    assign gif.key_find   = key_find_q;
    assign gif.todo       = todo_q;
    assign gif.play_valid = play_valid_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed walkthrough of the game rules
// followed by randomized pulses compared against a rule-level reference model.
module tb_game_flow_ctrl;

    localparam int KEYS_NEEDED     = 3;
    localparam int HIT_GUARD       = 10;
    localparam int SUCCESS_TIMEOUT = 20;
    localparam int CNT_W           = 8;

    localparam logic [7:0] E_NONE  = 8'h00;
    localparam logic [7:0] E_GO    = 8'h01;
    localparam logic [7:0] E_NEXT  = 8'h02;
    localparam logic [7:0] E_BACK  = 8'h04;
    localparam logic [7:0] E_RETRY = 8'h08;
    localparam logic [7:0] E_KEY   = 8'h10;
    localparam logic [7:0] E_LIGHT = 8'h20;
    localparam logic [7:0] E_DOOR  = 8'h40;
    localparam logic [7:0] E_HIT   = 8'h80;

    logic clk = 1'b0;
    logic rst;

    game_flow_ctrl_if gif();

    game_flow_ctrl #(
        .KEYS_NEEDED    (KEYS_NEEDED),
        .HIT_GUARD      (HIT_GUARD),
        .SUCCESS_TIMEOUT(SUCCESS_TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gif(gif)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference model: screen number, lives, keys, task, unlock mask, last stage index.
    int         m_state;
    int         m_heart;
    int         m_keys;
    int         m_todo;
    int         m_last;
    logic [3:0] m_pv;
    longint     cyc;
    longint     m_last_hit;
    longint     m_entry;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".state"},      32'(gif.state),      32'(m_state));
        check_eq({tag, ".heart"},      32'(gif.heart),      32'(m_heart));
        check_eq({tag, ".key_find"},   32'(gif.key_find),   32'(m_keys));
        check_eq({tag, ".todo"},       32'(gif.todo),       32'(m_todo));
        check_eq({tag, ".play_valid"}, 32'(gif.play_valid), 32'(m_pv));
    endtask

    task automatic model_reset();
        m_state = 0;
        m_heart = 0;
        m_keys  = 0;
        m_todo  = 0;
        m_last  = 1;
        m_pv    = 4'b0010;
    endtask

    task automatic enter_stage(input int k);
        m_state    = 2 * k;
        m_heart    = 3;
        m_keys     = 0;
        m_todo     = 1;
        m_last     = k;
        m_last_hit = cyc - HIT_GUARD - 1;
    endtask

    task automatic enter_success(input int k);
        m_state = 2 * k + 1;
        m_todo  = 0;
        m_entry = cyc;
        if (k == 1) m_pv[2] = 1'b1;
        if (k == 2) m_pv[3] = 1'b1;
        if (k == 3) m_pv[0] = 1'b1;
    endtask

    task automatic model_step(input logic [7:0] ev, input int sel);
        int k;
        bit hit_ok;
        bit left;
        case (m_state)
            0: begin
                if (ev[0]) begin
                    if (sel == 0) m_state = 1;
                    else if (sel == 1 || (sel == 2 && m_pv[2]) || (sel == 3 && m_pv[3])) enter_stage(sel);
                end
            end
            1: if (ev[2]) m_state = 0;
            2, 4, 6: begin
                k      = m_state / 2;
                hit_ok = ev[7] && (cyc - m_last_hit > HIT_GUARD);
                if (hit_ok && m_heart == 1) begin
                    m_state = 8;
                    m_heart = 0;
                    m_todo  = 0;
                end else begin
                    if (hit_ok) begin
                        m_heart--;
                        m_last_hit = cyc;
                    end
                    left = 1'b0;
                    if (m_todo == 1 && ev[4]) begin
                        if (m_keys < 3) m_keys++;
                        if (m_keys == KEYS_NEEDED) m_todo = 2;
                    end else if (m_todo == 2 && ev[5]) begin
                        m_todo = 3;
                    end else if (m_todo == 3 && ev[6]) begin
                        enter_success(k);
                        left = 1'b1;
                    end
                    if (!left && ev[2]) m_state = 0;
                end
            end
            3, 5, 7: begin
                k = (m_state - 1) / 2;
                if (ev[1]) begin
                    if (k < 3) enter_stage(k + 1);
                    else m_state = 1;
                end else if (ev[2] || (cyc - m_entry >= SUCCESS_TIMEOUT)) begin
                    m_state = 0;
                end
            end
            8: begin
                if (ev[3]) enter_stage(m_last);
                else if (ev[2]) m_state = 0;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic drive(input logic [7:0] ev, input logic [1:0] sel);
        gif.btn_go       = ev[0];
        gif.btn_next     = ev[1];
        gif.btn_back     = ev[2];
        gif.btn_retry    = ev[3];
        gif.key_pick     = ev[4];
        gif.light_found  = ev[5];
        gif.door_reached = ev[6];
        gif.hit          = ev[7];
        gif.menu_sel     = sel;
    endtask

    // One clock: apply pulses, advance model on the edge, compare 1 ns later.
    task automatic step(input logic [7:0] ev, input logic [1:0] sel);
        drive(ev, sel);
        @(posedge clk);
        model_step(ev, int'(sel));
        cyc++;
        #1;
        drive(E_NONE, 2'd0);
        check_all("step");
    endtask

    task automatic finish_stage();
        repeat (KEYS_NEEDED) step(E_KEY, 2'd0);
        step(E_LIGHT, 2'd0);
        step(E_DOOR, 2'd0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] r_ev;
    logic [1:0] r_sel;

    initial begin
        rst = 1'b1;
        drive(E_NONE, 2'd0);
        model_reset();
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset.state", 32'(gif.state), 32'd0);
        check_eq("reset.heart", 32'(gif.heart), 32'd0);
        check_eq("reset.key_find", 32'(gif.key_find), 32'd0);
        check_eq("reset.todo", 32'(gif.todo), 32'd0);
        check_eq("reset.play_valid", 32'(gif.play_valid), 32'h2);

        step(E_GO, 2'd2);
        check_eq("locked_stage2", 32'(gif.state), 32'd0);
        step(E_GO, 2'd1);
        check_eq("enter1.state", 32'(gif.state), 32'd2);
        check_eq("enter1.heart", 32'(gif.heart), 32'd3);
        check_eq("enter1.todo", 32'(gif.todo), 32'd1);
        check_eq("enter1.play_valid", 32'(gif.play_valid), 32'h2);

        step(E_KEY, 2'd0);
        check_eq("key1", 32'(gif.key_find), 32'd1);
        step(E_KEY, 2'd0);
        step(E_KEY, 2'd0);
        check_eq("key3", 32'(gif.key_find), 32'd3);
        check_eq("todo_light", 32'(gif.todo), 32'd2);
        step(E_LIGHT, 2'd0);
        check_eq("todo_door", 32'(gif.todo), 32'd3);
        step(E_DOOR, 2'd0);
        check_eq("success1.state", 32'(gif.state), 32'd3);
        check_eq("success1.play_valid", 32'(gif.play_valid), 32'h6);
        step(E_NEXT, 2'd0);
        check_eq("next.state", 32'(gif.state), 32'd4);
        check_eq("next.heart", 32'(gif.heart), 32'd3);
        check_eq("next.key_find", 32'(gif.key_find), 32'd0);

        // Hit guard: hits 0, 5 and 11 cycles apart.
        step(E_HIT, 2'd0);
        check_eq("hit0", 32'(gif.heart), 32'd2);
        repeat (4) step(E_NONE, 2'd0);
        step(E_HIT, 2'd0);
        check_eq("hit5_guarded", 32'(gif.heart), 32'd2);
        repeat (5) step(E_NONE, 2'd0);
        step(E_HIT, 2'd0);
        check_eq("hit11", 32'(gif.heart), 32'd1);
        repeat (10) step(E_NONE, 2'd0);
        step(E_HIT, 2'd0);
        check_eq("fatal.state", 32'(gif.state), 32'd8);
        check_eq("fatal.heart", 32'(gif.heart), 32'd0);
        step(E_RETRY, 2'd0);
        check_eq("retry.state", 32'(gif.state), 32'd4);
        check_eq("retry.heart", 32'(gif.heart), 32'd3);

        // Fatal hit together with a valid door_reached.
        repeat (KEYS_NEEDED) step(E_KEY, 2'd0);
        step(E_LIGHT, 2'd0);
        step(E_HIT, 2'd0);
        repeat (10) step(E_NONE, 2'd0);
        step(E_HIT, 2'd0);
        repeat (10) step(E_NONE, 2'd0);
        step(E_HIT | E_DOOR, 2'd0);
        check_eq("hit_door.state", 32'(gif.state), 32'd8);
        check_eq("hit_door.play_valid", 32'(gif.play_valid), 32'h6);
        step(E_BACK, 2'd0);
        check_eq("fail_back", 32'(gif.state), 32'd0);

        // Success timeout on SUCCESS2.
        step(E_GO, 2'd2);
        check_eq("enter2", 32'(gif.state), 32'd4);
        finish_stage();
        check_eq("success2.play_valid", 32'(gif.play_valid), 32'he);
        repeat (SUCCESS_TIMEOUT - 1) step(E_NONE, 2'd0);
        check_eq("timeout_minus1", 32'(gif.state), 32'd5);
        step(E_NONE, 2'd0);
        check_eq("timeout", 32'(gif.state), 32'd0);

        step(E_GO, 2'd1);
        finish_stage();
        step(E_NEXT | E_BACK, 2'd0);
        check_eq("next_beats_back", 32'(gif.state), 32'd4);
        step(E_BACK, 2'd0);
        step(E_GO, 2'd3);
        check_eq("enter3", 32'(gif.state), 32'd6);
        step(E_KEY, 2'd0);

        // Asynchronous reset mid-stage, sampled before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst.state", 32'(gif.state), 32'd0);
        check_eq("midrst.heart", 32'(gif.heart), 32'd0);
        check_eq("midrst.key_find", 32'(gif.key_find), 32'd0);
        check_eq("midrst.todo", 32'(gif.todo), 32'd0);
        check_eq("midrst.play_valid", 32'(gif.play_valid), 32'h2);
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        step(E_GO, 2'd3);
        check_eq("relocked3", 32'(gif.state), 32'd0);

        // Randomized pulses against the reference model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 2) begin
                do_reset();
            end else begin
                r_ev     = E_NONE;
                r_sel    = 2'($urandom_range(0, 3));
                r_ev[0]  = ($urandom_range(0, 99) < 25);
                r_ev[1]  = ($urandom_range(0, 99) < 8);
                r_ev[2]  = ($urandom_range(0, 99) < 3);
                r_ev[3]  = ($urandom_range(0, 99) < 15);
                r_ev[4]  = ($urandom_range(0, 99) < 30);
                r_ev[5]  = ($urandom_range(0, 99) < 25);
                r_ev[6]  = ($urandom_range(0, 99) < 25);
                r_ev[7]  = ($urandom_range(0, 99) < 8);
                step(r_ev, r_sel);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
